// File: rtl/button_conditioner.sv
// Button conditioner: synchronises and debounces one raw push-button pin and
// produces a clean level, press/release pulses and an optional hold-to-repeat train.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter bit ACTIVE_LOW_IN   = 1'b0,
   parameter bit REPEAT_EN       = 1'b0,
   parameter int REPEAT_DELAY    = 6250000,
   parameter int REPEAT_PERIOD   = 2500000
) (
   input  logic CLK_25MHZ,
   input  logic RESET_N,
   input  logic BTN_IN,
   output logic BTN_LEVEL,
   output logic BTN_PRESS,
   output logic BTN_RELEASE,
   output logic BTN_REPEAT
);

   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0]  DB_ONE  = DB_W'(1);
   localparam logic [RPT_W-1:0] RPT_DLY = RPT_W'(REPEAT_DELAY);
   localparam logic [RPT_W-1:0] RPT_PER = RPT_W'(REPEAT_PERIOD);
   localparam logic [RPT_W-1:0] RPT_TOP = RPT_W'(RPT_MAX);

   localparam logic [1:0] ST_RELEASED     = 2'd0;
   localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
   localparam logic [1:0] ST_PRESSED      = 2'd2;
   localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

   logic             sync1, sync2, s;
   logic [1:0]       state, state_nxt;
   logic [DB_W-1:0]  dbcnt, dbcnt_nxt;
   logic             press_nxt, release_nxt;
   logic [RPT_W-1:0] rptcnt, rpt_inc, rpt_term;
   logic             rpt_first, rpt_pend, rpt_q;

   // Flops reset to the idle pin level so reset never looks like a press.
   always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1 <= ACTIVE_LOW_IN;
         sync2 <= ACTIVE_LOW_IN;
      end else begin
         sync1 <= BTN_IN;
         sync2 <= sync1;
      end
   end

   assign s = sync2 ^ ACTIVE_LOW_IN;

   always_comb begin
      state_nxt   = state;
      dbcnt_nxt   = dbcnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      case (state)
         ST_RELEASED: begin
            if (s) begin
               state_nxt = ST_PRESS_WAIT;
               dbcnt_nxt = DB_ONE;
            end
         end
         ST_PRESS_WAIT: begin
            if (!s) begin
               state_nxt = ST_RELEASED;
               dbcnt_nxt = '0;
            end else if (dbcnt == DB_MAX) begin
               state_nxt = ST_PRESSED;
               dbcnt_nxt = '0;
               press_nxt = 1'b1;
            end else begin
               dbcnt_nxt = dbcnt + DB_ONE;
            end
         end
         ST_PRESSED: begin
            if (!s) begin
               state_nxt = ST_RELEASE_WAIT;
               dbcnt_nxt = DB_ONE;
            end
         end
         ST_RELEASE_WAIT: begin
            if (s) begin
               state_nxt = ST_PRESSED;
               dbcnt_nxt = '0;
            end else if (dbcnt == DB_MAX) begin
               state_nxt   = ST_RELEASED;
               dbcnt_nxt   = '0;
               release_nxt = 1'b1;
            end else begin
               dbcnt_nxt = dbcnt + DB_ONE;
            end
         end
         default: begin
            state_nxt = ST_RELEASED;
            dbcnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= ST_RELEASED;
         dbcnt       <= '0;
         BTN_LEVEL   <= 1'b0;
         BTN_PRESS   <= 1'b0;
         BTN_RELEASE <= 1'b0;
      end else begin
         state       <= state_nxt;
         dbcnt       <= dbcnt_nxt;
         BTN_LEVEL   <= (state_nxt == ST_PRESSED) || (state_nxt == ST_RELEASE_WAIT);
         BTN_PRESS   <= press_nxt;
         BTN_RELEASE <= release_nxt;
      end
   end

   // rptcnt only advances while settled in PRESSED, so a release bounce stretches the phase.
   assign rpt_term = rpt_first ? RPT_DLY : RPT_PER;
   assign rpt_inc  = (rptcnt == RPT_TOP) ? rptcnt : rptcnt + RPT_W'(1);

   always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
      if (!RESET_N) begin
         rptcnt    <= '0;
         rpt_first <= 1'b1;
         rpt_pend  <= 1'b0;
         rpt_q     <= 1'b0;
      end else begin
         rpt_q <= 1'b0;
         if (press_nxt) begin
            rptcnt    <= '0;
            rpt_first <= 1'b1;
            rpt_pend  <= 1'b0;
         end else if (state == ST_PRESSED) begin
            if (rpt_inc == rpt_term) begin
               rptcnt    <= '0;
               rpt_first <= 1'b0;
               // a pulse due on the edge that leaves PRESSED waits for the bounce to resolve
               if (s) rpt_q    <= 1'b1;
               else   rpt_pend <= 1'b1;
            end else begin
               rptcnt <= rpt_inc;
            end
         end else if (state == ST_RELEASE_WAIT) begin
            if (s && rpt_pend) begin
               rpt_q    <= 1'b1;
               rpt_pend <= 1'b0;
            end else if (release_nxt) begin
               rpt_pend <= 1'b0;
            end
         end
      end
   end

   assign BTN_REPEAT = REPEAT_EN ? rpt_q : 1'b0;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: an active-high and an active-low instance checked
// every cycle against a run-length debounce model, plus directed timing checks.
module tb_button_conditioner;
   localparam int D   = 4;
   localparam int DLY = 8;
   localparam int PER = 3;

   logic clk = 1'b0, rst_n = 1'b0, in_a = 1'b0, in_b = 1'b1;
   logic lvl_a, prs_a, rel_a, rpt_a, lvl_b, prs_b, rel_b, rpt_b;
   int   cyc = 0, total = 0, passed = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   button_conditioner #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW_IN(1'b0), .REPEAT_EN(1'b1),
                        .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) u_a (
      .CLK_25MHZ(clk), .RESET_N(rst_n), .BTN_IN(in_a), .BTN_LEVEL(lvl_a),
      .BTN_PRESS(prs_a), .BTN_RELEASE(rel_a), .BTN_REPEAT(rpt_a));

   button_conditioner #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW_IN(1'b1), .REPEAT_EN(1'b1),
                        .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) u_b (
      .CLK_25MHZ(clk), .RESET_N(rst_n), .BTN_IN(in_b), .BTN_LEVEL(lvl_b),
      .BTN_PRESS(prs_b), .BTN_RELEASE(rel_b), .BTN_REPEAT(rpt_b));

   // Level flips once s has disagreed with it for D+1 consecutive edges; repeats are
   // scheduled by how many settled-hold edges have elapsed since the press.
   typedef struct {
      bit al; bit q1; bit q2; int run; bit level; int counted; bit pend;
      bit prs; bit rls; bit rpt;
   } model_t;

   function automatic model_t model_reset(bit al);
      model_t m;
      m.al = al; m.q1 = al; m.q2 = al; m.run = 0; m.level = 1'b0; m.counted = 0;
      m.pend = 1'b0; m.prs = 1'b0; m.rls = 1'b0; m.rpt = 1'b0;
      return m;
   endfunction

   function automatic model_t model_step(model_t m, bit in);
      model_t n;
      bit s;
      n = m;
      s = m.q2 ^ m.al;
      n.q1 = in; n.q2 = m.q1;
      n.prs = 1'b0; n.rls = 1'b0; n.rpt = 1'b0;
      if (m.level && m.run == 0) begin
         n.counted = m.counted + 1;
         if (n.counted >= DLY && (n.counted - DLY) % PER == 0) begin
            if (s) n.rpt = 1'b1;
            else   n.pend = 1'b1;
         end
      end else if (m.level && s && m.pend) begin
         n.rpt = 1'b1; n.pend = 1'b0;
      end
      if (s != m.level) begin
         n.run = m.run + 1;
         if (n.run == D + 1) begin
            n.level = ~m.level; n.run = 0; n.pend = 1'b0; n.counted = 0;
            n.prs = n.level; n.rls = ~n.level;
         end
      end else begin
         n.run = 0;
      end
      return n;
   endfunction

   model_t ma, mb;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ma <= model_reset(1'b0);
         mb <= model_reset(1'b1);
      end else begin
         ma <= model_step(ma, in_a);
         mb <= model_step(mb, in_b);
      end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act === want) passed++;
      else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, want, cyc);
   endtask

   int prs_cnt_a = 0, rls_cnt_a = 0, rpt_cnt_a = 0, lvl_lo_a = 0, last_prs_a = 0, last_rls_a = 0;
   int prs_cnt_b = 0, rls_cnt_b = 0, last_prs_b = 0;
   int rpt_cyc [0:1023];

   always @(negedge clk)
      if (rst_n) begin
         chk("level_a", lvl_a, ma.level);   chk("press_a", prs_a, ma.prs);
         chk("release_a", rel_a, ma.rls);   chk("repeat_a", rpt_a, ma.rpt);
         chk("level_b", lvl_b, mb.level);   chk("press_b", prs_b, mb.prs);
         chk("release_b", rel_b, mb.rls);   chk("repeat_b", rpt_b, mb.rpt);
         if (prs_a) begin prs_cnt_a <= prs_cnt_a + 1; last_prs_a <= cyc; end
         if (rel_a) begin rls_cnt_a <= rls_cnt_a + 1; last_rls_a <= cyc; end
         if (rpt_a) begin rpt_cyc[rpt_cnt_a % 1024] <= cyc; rpt_cnt_a <= rpt_cnt_a + 1; end
         if (!lvl_a) lvl_lo_a <= lvl_lo_a + 1;
         if (prs_b) begin prs_cnt_b <= prs_cnt_b + 1; last_prs_b <= cyc; end
         if (rel_b) rls_cnt_b <= rls_cnt_b + 1;
      end

   task automatic set_a(input logic v, output int cap);
      @(posedge clk); #2; in_a = v; cap = cyc + 1;
   endtask

   task automatic set_b(input logic v, output int cap);
      @(posedge clk); #2; in_b = v; cap = cyc + 1;
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_level_a"}, lvl_a, 0); chk({tag, "_press_a"}, prs_a, 0);
      chk({tag, "_release_a"}, rel_a, 0); chk({tag, "_repeat_a"}, rpt_a, 0);
      chk({tag, "_level_b"}, lvl_b, 0); chk({tag, "_press_b"}, prs_b, 0);
   endtask

   task automatic wait_rpt(input int rb, input int need, input string tag);
      int t;
      t = 0;
      while (rpt_cnt_a - rb < need && t < 40) begin
         @(negedge clk); #1; t++;
      end
      chk(tag, (rpt_cnt_a - rb >= need) ? 1 : 0, 1);
   endtask

   initial begin
      int cap, e0, p, rb, base, lbase, rlb, cnt;
      #12;
      chk_zero("reset");
      @(negedge clk); #1 rst_n = 1'b1;
      repeat (6) @(posedge clk);

      // clean press: level and pulse D+2 edges after capture, then repeat schedule
      base = prs_cnt_a;
      set_a(1'b1, cap);
      wait_n(12);
      chk("t1_press_count", prs_cnt_a - base, 1);
      chk("t1_press_latency", last_prs_a - cap, 6);
      chk("t1_level_high", lvl_a, 1);
      p = last_prs_a;
      rb = rpt_cnt_a;
      wait_rpt(rb, 2, "t3_repeat_wait");
      // 2-cycle low glitch while held
      lbase = lvl_lo_a; rlb = rls_cnt_a;
      set_a(1'b0, cap);
      set_a(1'b0, cap);
      set_a(1'b1, cap);
      wait_n(20);
      chk("t3_first_repeat", rpt_cyc[rb % 1024] - p, 8);
      chk("t3_second_repeat", rpt_cyc[(rb + 1) % 1024] - p, 11);
      chk("t3_third_repeat", rpt_cyc[(rb + 2) % 1024] - p, 14);
      chk("t4_glitch_gap", rpt_cyc[(rb + 3) % 1024] - rpt_cyc[(rb + 2) % 1024], 5);
      chk("t4_no_release", rls_cnt_a - rlb, 0);
      chk("t4_level_held", lvl_lo_a - lbase, 0);

      // release: symmetric latency, no repeat afterwards
      rb = rpt_cnt_a; rlb = rls_cnt_a;
      set_a(1'b0, cap);
      wait_n(25);
      chk("t1_release_count", rls_cnt_a - rlb, 1);
      chk("t1_release_latency", last_rls_a - cap, 6);
      chk("t1_level_low", lvl_a, 0);
      cnt = 0;
      for (int i = rb; i < rpt_cnt_a; i++)
         if (rpt_cyc[i % 1024] > last_rls_a) cnt++;
      chk("t3_repeat_after_release", cnt, 0);

      // bounce 1,0,1,0 then hold
      base = prs_cnt_a;
      set_a(1'b1, cap); set_a(1'b0, cap); set_a(1'b1, cap); set_a(1'b0, cap);
      set_a(1'b1, cap);
      wait_n(14);
      chk("t2_press_count", prs_cnt_a - base, 1);
      chk("t2_press_latency", last_prs_a - cap, 6);
      set_a(1'b0, cap);
      wait_n(12);

      // reset mid-PRESS_WAIT, then fresh press
      set_a(1'b1, cap);
      wait_n(3);
      rst_n = 1'b0; #1;
      chk_zero("t5_pw_reset");
      @(negedge clk); #1 rst_n = 1'b1;
      e0 = cyc + 1;
      wait_n(10);
      chk("t5_fresh_press_1", last_prs_a - e0, 6);
      // reset while a repeat pulse is high
      rb = rpt_cnt_a;
      wait_rpt(rb, 1, "t5_repeat_wait");
      chk("t5_repeat_high", rpt_a, 1);
      rst_n = 1'b0; #1;
      chk_zero("t5_rpt_reset");
      @(negedge clk); #1 rst_n = 1'b1;
      e0 = cyc + 1;
      wait_n(10);
      chk("t5_fresh_press_2", last_prs_a - e0, 6);
      set_a(1'b0, cap);
      wait_n(14);

      // active-low instance: idle-high pin never pulsed; driving 0 presses
      chk("t6_b_no_press", prs_cnt_b, 0);
      chk("t6_b_no_release", rls_cnt_b, 0);
      set_b(1'b0, cap);
      wait_n(12);
      chk("t6_b_press_latency", last_prs_b - cap, 6);
      chk("t6_b_level_high", lvl_b, 1);
      set_b(1'b1, cap);
      wait_n(12);

      // randomized runs, model compared every cycle
      for (int i = 0; i < 70; i++) begin
         int n;
         n = ($urandom_range(0, 3) == 0) ? $urandom_range(14, 30) : $urandom_range(1, 7);
         @(posedge clk); #2;
         in_a = ~in_a;
         in_b = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 24) == 0) begin
            rst_n = 1'b0; #1;
            chk("rnd_reset_level_a", lvl_a, 0);
            chk("rnd_reset_repeat_a", rpt_a, 0);
            rst_n = 1'b1;
         end
         repeat (n - 1) @(posedge clk);
      end
      wait_n(5);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
